pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer with fetch handshake and a
//               3-entry call stack.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        fetch_start,
  output logic [11:0] fetch_pc,
  input  logic        fetch_done,
  input  logic [2:0]  inst_len,
  output logic        inst_ready,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd,
  input  logic [11:0] cmd_target,
  output logic [11:0] pc,
  output logic [1:0]  stack_depth,
  output logic        stack_err
);

  localparam logic [2:0] c_CMD_NEXT      = 3'd0;
  localparam logic [2:0] c_CMD_JUMP      = 3'd1;
  localparam logic [2:0] c_CMD_CALL      = 3'd2;
  localparam logic [2:0] c_CMD_RETURN    = 3'd3;
  localparam logic [2:0] c_CMD_JUMP_PAGE = 3'd4;
  localparam logic [2:0] c_CMD_HALT      = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_WAIT_FETCH = 2'd2,
    ST_WAIT_CMD   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [11:0] stk_q [3];
  logic [11:0] stk_d [3];
  logic [1:0]  depth_q, depth_d;
  logic        err_q, err_d;
  logic [11:0] w_next_seq;

  // Wraps naturally at 12 bits.
  assign w_next_seq = pc_q + ((inst_len == 3'd2) ? 12'd2 : 12'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= 12'h000;
      stk_q   <= '{default: 12'h000};
      depth_q <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stk_q   <= stk_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stk_d   = stk_q;
    depth_d = depth_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE:       if (run) state_d = ST_ISSUE;
      ST_ISSUE:      state_d = ST_WAIT_FETCH;
      ST_WAIT_FETCH: if (fetch_done) state_d = ST_WAIT_CMD;
      ST_WAIT_CMD: begin
        if (cmd_valid) begin
          state_d = ((cmd == c_CMD_HALT) || !run) ? ST_IDLE : ST_ISSUE;
          case (cmd)
            c_CMD_JUMP: pc_d = cmd_target;
            c_CMD_CALL: begin
              pc_d = cmd_target;
              if (depth_q == 2'd3) begin
                // Full stack: drop the oldest return address.
                stk_d[0] = stk_q[1];
                stk_d[1] = stk_q[2];
                stk_d[2] = w_next_seq;
                err_d    = 1'b1;
              end else begin
                stk_d[depth_q] = w_next_seq;
                depth_d        = depth_q + 2'd1;
              end
            end
            c_CMD_RETURN: begin
              if (depth_q == 2'd0) begin
                pc_d  = 12'h000;
                err_d = 1'b1;
              end else begin
                pc_d    = stk_q[depth_q - 2'd1];
                depth_d = depth_q - 2'd1;
              end
            end
            c_CMD_JUMP_PAGE: pc_d = {w_next_seq[11:8], cmd_target[7:0]};
            c_CMD_NEXT:      pc_d = w_next_seq;
            default:         pc_d = w_next_seq;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fetch_start = (state_q == ST_ISSUE);
  assign inst_ready  = (state_q == ST_WAIT_CMD);
  assign fetch_pc    = pc_q;
  assign pc          = pc_q;
  assign stack_depth = depth_q;
  assign stack_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Scoreboard bench for pc_sequencer; every fetch is checked
//               against an expected {pc, depth, err} queued by the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        fetch_start;
  logic [11:0] fetch_pc;
  logic        fetch_done = 1'b0;
  logic [2:0]  inst_len = 3'd1;
  logic        inst_ready;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd = 3'd0;
  logic [11:0] cmd_target = 12'h000;
  logic [11:0] pc;
  logic [1:0]  stack_depth;
  logic        stack_err;

  typedef struct packed {
    logic [11:0] pc;
    logic [1:0]  depth;
    logic        err;
  } exp_t;

  exp_t exp_q [$];
  int   total = 0;
  int   bad = 0;
  logic auto_fetch = 1'b1;
  logic prev_fs = 1'b0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .run(run),
    .fetch_start(fetch_start), .fetch_pc(fetch_pc), .fetch_done(fetch_done),
    .inst_len(inst_len), .inst_ready(inst_ready),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_target(cmd_target),
    .pc(pc), .stack_depth(stack_depth), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [11:0] p, input logic [1:0] d, input logic e);
    exp_t r;
    r.pc = p; r.depth = d; r.err = e;
    return r;
  endfunction

  // Fetcher model: completes two cycles after each request.
  initial forever begin
    @(negedge clk);
    if (fetch_start && auto_fetch) begin
      repeat (2) @(negedge clk);
      fetch_done = 1'b1;
      @(negedge clk);
      fetch_done = 1'b0;
    end
  end

  // Monitor: every fetch request pops one expectation.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      prev_fs = 1'b0;
    end else begin
      if (fetch_start) begin
        chk("fetch_start_width", {31'd0, prev_fs}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_fetch: got fetch_pc %h expected no fetch", fetch_pc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("fetch_pc", {20'd0, fetch_pc}, {20'd0, e.pc});
          chk("pc_at_fetch", {20'd0, pc}, {20'd0, e.pc});
          chk("stack_depth", {30'd0, stack_depth}, {30'd0, e.depth});
          chk("stack_err", {31'd0, stack_err}, {31'd0, e.err});
        end
      end
      prev_fs = fetch_start;
    end
  end

  task automatic do_cmd(input logic [2:0] c, input logic [11:0] tgt, input logic [2:0] len,
                        input logic expect_fetch, input exp_t e);
    int n;
    n = 0;
    while (!inst_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!inst_ready) begin
      total++;
      bad++;
      $display("FAIL inst_ready_timeout: got 0 expected 1");
      return;
    end
    if (expect_fetch) exp_q.push_back(e);
    cmd = c; cmd_target = tgt; inst_len = len; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n;
    // Reset with run and cmd_valid asserted.
    run = 1'b1; cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_fetch_start", {31'd0, fetch_start}, 32'd0);
    chk("rst_inst_ready", {31'd0, inst_ready}, 32'd0);
    chk("rst_pc", {20'd0, pc}, 32'h000);
    chk("rst_depth", {30'd0, stack_depth}, 32'd0);
    chk("rst_err", {31'd0, stack_err}, 32'd0);
    reset = 1'b0; cmd_valid = 1'b0; run = 1'b0;
    @(negedge clk);

    // Sequential run
    exp_q.push_back(mk(12'h000, 2'd0, 1'b0));
    run = 1'b1;
    do_cmd(3'd0, 12'h000, 3'd1, 1'b1, mk(12'h001, 2'd0, 1'b0));
    do_cmd(3'd0, 12'h000, 3'd1, 1'b1, mk(12'h002, 2'd0, 1'b0));
    do_cmd(3'd0, 12'h000, 3'd1, 1'b1, mk(12'h003, 2'd0, 1'b0));

    // Two-byte and wrap
    do_cmd(3'd1, 12'hFFE, 3'd1, 1'b1, mk(12'hFFE, 2'd0, 1'b0));
    do_cmd(3'd0, 12'h000, 3'd2, 1'b1, mk(12'h000, 2'd0, 1'b0));
    do_cmd(3'd1, 12'hFFF, 3'd1, 1'b1, mk(12'hFFF, 2'd0, 1'b0));
    do_cmd(3'd0, 12'h000, 3'd1, 1'b1, mk(12'h000, 2'd0, 1'b0));

    // Call/return
    do_cmd(3'd1, 12'h010, 3'd1, 1'b1, mk(12'h010, 2'd0, 1'b0));
    do_cmd(3'd2, 12'h200, 3'd2, 1'b1, mk(12'h200, 2'd1, 1'b0));
    do_cmd(3'd3, 12'h000, 3'd1, 1'b1, mk(12'h012, 2'd0, 1'b0));

    // Overflow then underflow
    do_cmd(3'd1, 12'h100, 3'd1, 1'b1, mk(12'h100, 2'd0, 1'b0));
    do_cmd(3'd2, 12'h200, 3'd1, 1'b1, mk(12'h200, 2'd1, 1'b0));
    do_cmd(3'd2, 12'h300, 3'd1, 1'b1, mk(12'h300, 2'd2, 1'b0));
    do_cmd(3'd2, 12'h400, 3'd1, 1'b1, mk(12'h400, 2'd3, 1'b0));
    do_cmd(3'd2, 12'h500, 3'd1, 1'b1, mk(12'h500, 2'd3, 1'b1));
    do_cmd(3'd3, 12'h000, 3'd1, 1'b1, mk(12'h401, 2'd2, 1'b1));
    do_cmd(3'd3, 12'h000, 3'd1, 1'b1, mk(12'h301, 2'd1, 1'b1));
    do_cmd(3'd3, 12'h000, 3'd1, 1'b1, mk(12'h201, 2'd0, 1'b1));
    do_cmd(3'd3, 12'h000, 3'd1, 1'b1, mk(12'h000, 2'd0, 1'b1));

    // Jump page and reserved opcode
    do_cmd(3'd1, 12'h3FF, 3'd1, 1'b1, mk(12'h3FF, 2'd0, 1'b1));
    do_cmd(3'd4, 12'h0A5, 3'd1, 1'b1, mk(12'h4A5, 2'd0, 1'b1));
    do_cmd(3'd6, 12'h123, 3'd1, 1'b1, mk(12'h4A6, 2'd0, 1'b1));

    // HALT with run held: the IDLE entry cycle must not fetch
    do_cmd(3'd5, 12'h000, 3'd1, 1'b0, mk(12'h000, 2'd0, 1'b0));
    chk("halt_fetch_start", {31'd0, fetch_start}, 32'd0);
    chk("halt_inst_ready", {31'd0, inst_ready}, 32'd0);
    chk("halt_pc", {20'd0, pc}, 32'h4A7);
    run = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during WAIT_FETCH with cmd_valid asserted
    auto_fetch = 1'b0;
    exp_q.push_back(mk(12'h4A7, 2'd0, 1'b1));
    run = 1'b1;
    n = 0;
    while (!fetch_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reissue_seen", {31'd0, fetch_start}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b1; reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_fetch_start", {31'd0, fetch_start}, 32'd0);
    chk("mid_rst_inst_ready", {31'd0, inst_ready}, 32'd0);
    chk("mid_rst_pc", {20'd0, pc}, 32'h000);
    chk("mid_rst_err", {31'd0, stack_err}, 32'd0);
    run = 1'b0; cmd_valid = 1'b0; reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("pending_expectations", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
